// File: rtl/lsu_pkg.sv
// lsu_pkg: access size encodings, FSM states and size-to-byte-count helper for the LSU bus master
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;
  function automatic int bytes_of(logic [1:0] size);
    return 1 << size;
  endfunction
endpackage

// File: rtl/lsu_bus_master_if.sv
// lsu_bus_master_if: sequencer request/response and memory bus signals; master = LSU side, slave = environment side
interface lsu_bus_master_if #(parameter int XLEN = 32);
  logic req_valid, req_ready, req_we, req_signed;
  logic [1:0] req_size;
  logic [XLEN-1:0] req_addr, req_wdata;
  logic rsp_valid, rsp_err;
  logic [XLEN-1:0] rsp_rdata;
  logic bus_req, bus_we, bus_ack, bus_err;
  logic [XLEN-1:0] bus_addr, bus_wdata, bus_rdata;
  logic [XLEN/8-1:0] bus_wstrb;
  modport master (
    input req_valid, req_we, req_size, req_signed, req_addr, req_wdata, bus_ack, bus_rdata, bus_err,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
  );
  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, bus_ack, bus_rdata, bus_err,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: gathers load bytes from beats lo/hi starting at lane off, right-justifies, then sign/zero-extends from size -> data
module lsu_load_align import lsu_pkg::*; #(parameter int XLEN = 32) (
  input  logic [XLEN-1:0]            lo,
  input  logic [XLEN-1:0]            hi,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic [1:0]                 size,
  input  logic                       sgn,
  output logic [XLEN-1:0]            data
);
  logic [XLEN-1:0] raw, mask, top;
  always_comb begin
    raw = XLEN'({hi, lo} >> {off, 3'b000});
    mask = bytes_of(size) * 8 >= XLEN ? '0 : {XLEN{1'b1}} << (bytes_of(size) * 8);
    top = bytes_of(size) * 8 >= XLEN ? {1'b1, {(XLEN-1){1'b0}}} : ~mask & (mask >> 1);
    data = (raw & ~mask) | (sgn && |(raw & top) ? mask : '0);
  end
endmodule

// File: rtl/lsu_bus_master.sv
// lsu_bus_master: load/store bus master with ack handshake, timeout and two-beat misaligned split; ports clk, rst (async high), bus (request/response + memory bus)
module lsu_bus_master import lsu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  lsu_bus_master_if.master bus
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int SW = 2 * NB;
  state_t state, state_n;
  logic [XLEN-1:0] addr_q, wdata_q, b1_q, b1_n, rdata_q, rdata_n, ld_data, base;
  logic [1:0] size_q;
  logic we_q, sgn_q, err_q, err_n, split, illegal;
  logic [31:0] cnt, cnt_n;
  logic [OW-1:0] off;
  logic [2*XLEN-1:0] st_data;
  logic [SW-1:0] st_strb;
  assign off = addr_q[OW-1:0];
  assign base = {addr_q[XLEN-1:OW], {OW{1'b0}}};
  assign split = int'(off) + bytes_of(size_q) > NB;
  assign illegal = XLEN == 32 && bus.req_size == SZ_D;
  // lower half feeds beat1 lanes, upper half holds the bytes that spill into beat2
  assign st_data = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
  assign st_strb = SW'((1 << bytes_of(size_q)) - 1) << off;
  // beat1 data arrives live on BEAT1 ack; on BEAT2 ack it comes from the captured copy
  lsu_load_align #(.XLEN(XLEN)) u_align (
    .lo(state == BEAT1 ? bus.bus_rdata : b1_q),
    .hi(bus.bus_rdata),
    .off(off),
    .size(size_q),
    .sgn(sgn_q),
    .data(ld_data)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      err_q <= 1'b0;
      b1_q <= '0;
      rdata_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      size_q <= '0;
      we_q <= 1'b0;
      sgn_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      err_q <= err_n;
      b1_q <= b1_n;
      rdata_q <= rdata_n;
      if (state == IDLE && bus.req_valid) begin
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        size_q <= bus.req_size;
        we_q <= bus.req_we;
        sgn_q <= bus.req_signed;
      end
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    err_n = err_q;
    b1_n = b1_q;
    rdata_n = rdata_q;
    bus.req_ready = state == IDLE;
    bus.bus_req = state == BEAT1 || state == BEAT2;
    bus.bus_we = bus.bus_req && we_q;
    bus.bus_addr = state == BEAT1 ? base : state == BEAT2 ? base + XLEN'(NB) : '0;
    bus.bus_wstrb = !we_q ? '0 : state == BEAT1 ? st_strb[NB-1:0] : state == BEAT2 ? st_strb[SW-1:NB] : '0;
    bus.bus_wdata = !we_q ? '0 : state == BEAT1 ? st_data[XLEN-1:0] : state == BEAT2 ? st_data[2*XLEN-1:XLEN] : '0;
    bus.rsp_valid = state == RESP;
    bus.rsp_rdata = bus.rsp_valid ? rdata_q : '0;
    bus.rsp_err = bus.rsp_valid && err_q;
    if (state == IDLE && bus.req_valid) begin
      state_n = illegal ? RESP : BEAT1;
      err_n = illegal;
      rdata_n = '0;
      cnt_n = '0;
    end else if (bus.bus_req && bus.bus_ack) begin
      cnt_n = '0;
      b1_n = bus.bus_rdata;
      err_n = bus.bus_err;
      state_n = state == BEAT1 && !bus.bus_err && split ? BEAT2 : RESP;
      rdata_n = we_q || bus.bus_err ? '0 : ld_data;
    end else if (bus.bus_req) begin
      cnt_n = cnt + 1;
      if (TIMEOUT != 0 && cnt_n == 32'(TIMEOUT)) begin
        state_n = RESP;
        err_n = 1'b1;
        rdata_n = '0;
      end
    end else if (state == RESP) state_n = IDLE;
  end
endmodule

// File: tb/tb_lsu_bus_master.sv
// tb_lsu_bus_master: directed tests of lsu_bus_master at XLEN=32 (TIMEOUT=4) and XLEN=64
module tb_lsu_bus_master;
  import lsu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  lsu_bus_master_if #(.XLEN(32)) i32 ();
  lsu_bus_master_if #(.XLEN(64)) i64 ();
  lsu_bus_master #(.XLEN(32), .TIMEOUT(4)) dut32 (.clk(clk), .rst(rst), .bus(i32.master));
  lsu_bus_master #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(i64.master));
  always #5 clk = ~clk;

  task automatic req32(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    i32.req_valid = 1'b1;
    i32.req_we = we;
    i32.req_size = size;
    i32.req_signed = sgn;
    i32.req_addr = addr;
    i32.req_wdata = wdata;
    @(negedge clk);
    i32.req_valid = 1'b0;
  endtask

  task automatic ack32(input logic [31:0] rdata, input logic err);
    i32.bus_ack = 1'b1;
    i32.bus_rdata = rdata;
    i32.bus_err = err;
    @(negedge clk);
    i32.bus_ack = 1'b0;
    i32.bus_rdata = '0;
    i32.bus_err = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    i32.req_valid = 1'b0; i32.req_we = 1'b0; i32.req_size = SZ_B; i32.req_signed = 1'b0;
    i32.req_addr = '0; i32.req_wdata = '0; i32.bus_ack = 1'b0; i32.bus_rdata = '0; i32.bus_err = 1'b0;
    i64.req_valid = 1'b0; i64.req_we = 1'b0; i64.req_size = SZ_B; i64.req_signed = 1'b0;
    i64.req_addr = '0; i64.req_wdata = '0; i64.bus_ack = 1'b0; i64.bus_rdata = '0; i64.bus_err = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({i32.req_ready, i32.bus_req, i32.bus_we, i32.rsp_valid, i32.rsp_err} !== 5'b10000) begin
      fails++; $display("FAIL reset_ctrl32: got %b want 10000", {i32.req_ready, i32.bus_req, i32.bus_we, i32.rsp_valid, i32.rsp_err});
    end
    checks++;
    if ({i32.bus_addr, i32.bus_wstrb, i32.bus_wdata, i32.rsp_rdata} !== '0) begin
      fails++; $display("FAIL reset_data32: addr %h strb %b wdata %h rdata %h want all 0", i32.bus_addr, i32.bus_wstrb, i32.bus_wdata, i32.rsp_rdata);
    end
    checks++;
    if ({i64.req_ready, i64.bus_req, i64.rsp_valid} !== 3'b100) begin
      fails++; $display("FAIL reset_ctrl64: got %b want 100", {i64.req_ready, i64.bus_req, i64.rsp_valid});
    end
    rst = 1'b0;
  endtask

  task automatic test_load_word;
    req32(1'b0, SZ_W, 1'b0, 32'h200, '0);
    checks++;
    if ({i32.bus_req, i32.bus_we, i32.bus_wstrb, i32.rsp_valid, i32.req_ready} !== 8'b1_0_0000_0_0) begin
      fails++; $display("FAIL ldw_beat_ctrl: req %b we %b strb %b rsp %b rdy %b want 1 0 0000 0 0", i32.bus_req, i32.bus_we, i32.bus_wstrb, i32.rsp_valid, i32.req_ready);
    end
    checks++;
    if (i32.bus_addr !== 32'h200) begin fails++; $display("FAIL ldw_addr: got %h want 00000200", i32.bus_addr); end
    ack32(32'hDEADBEEF, 1'b0);
    checks++;
    if ({i32.rsp_valid, i32.rsp_err, i32.bus_req} !== 3'b100) begin
      fails++; $display("FAIL ldw_rsp: valid/err/req got %b want 100", {i32.rsp_valid, i32.rsp_err, i32.bus_req});
    end
    checks++;
    if (i32.rsp_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL ldw_rdata: got %h want deadbeef", i32.rsp_rdata); end
    @(negedge clk);
    checks++;
    if ({i32.rsp_valid, i32.req_ready} !== 2'b01) begin
      fails++; $display("FAIL ldw_pulse: valid/ready got %b want 01", {i32.rsp_valid, i32.req_ready});
    end
  endtask

  task automatic test_split_load(input logic sgn, input logic [31:0] exp);
    req32(1'b0, SZ_H, sgn, 32'h103, '0);
    checks++;
    if (i32.bus_addr !== 32'h100) begin fails++; $display("FAIL spl_b1_addr: got %h want 00000100", i32.bus_addr); end
    ack32(32'h80563412, 1'b0);
    checks++;
    if ({i32.bus_req, i32.rsp_valid} !== 2'b10 || i32.bus_addr !== 32'h104) begin
      fails++; $display("FAIL spl_b2: req/rsp %b addr %h want 10 00000104", {i32.bus_req, i32.rsp_valid}, i32.bus_addr);
    end
    ack32(32'hAABBCCFF, 1'b0);
    checks++;
    if ({i32.rsp_valid, i32.rsp_err} !== 2'b10 || i32.rsp_rdata !== exp) begin
      fails++; $display("FAIL spl_rdata s=%b: valid/err %b rdata %h want 10 %h", sgn, {i32.rsp_valid, i32.rsp_err}, i32.rsp_rdata, exp);
    end
  endtask

  task automatic test_split_store;
    req32(1'b1, SZ_W, 1'b0, 32'h102, 32'h11223344);
    checks++;
    if (i32.bus_addr !== 32'h100 || i32.bus_wstrb !== 4'b1100 || i32.bus_wdata[31:16] !== 16'h3344 || i32.bus_we !== 1'b1) begin
      fails++; $display("FAIL st_b1: addr %h strb %b wdata %h we %b want 00000100 1100 3344xxxx 1", i32.bus_addr, i32.bus_wstrb, i32.bus_wdata, i32.bus_we);
    end
    ack32('0, 1'b0);
    checks++;
    if (i32.bus_addr !== 32'h104 || i32.bus_wstrb !== 4'b0011 || i32.bus_wdata[15:0] !== 16'h1122) begin
      fails++; $display("FAIL st_b2: addr %h strb %b wdata %h want 00000104 0011 xxxx1122", i32.bus_addr, i32.bus_wstrb, i32.bus_wdata);
    end
    ack32('0, 1'b0);
    checks++;
    if ({i32.rsp_valid, i32.rsp_err} !== 2'b10 || i32.rsp_rdata !== '0) begin
      fails++; $display("FAIL st_rsp: valid/err %b rdata %h want 10 00000000", {i32.rsp_valid, i32.rsp_err}, i32.rsp_rdata);
    end
  endtask

  task automatic test_wait_states;
    req32(1'b0, SZ_B, 1'b1, 32'h205, '0);
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      checks++;
      if ({i32.bus_req, i32.rsp_valid} !== 2'b10 || i32.bus_addr !== 32'h204) begin
        fails++; $display("FAIL wait%0d: req/rsp %b addr %h want 10 00000204", w, {i32.bus_req, i32.rsp_valid}, i32.bus_addr);
      end
    end
    ack32(32'h00009C00, 1'b0);
    checks++;
    if (i32.rsp_valid !== 1'b1 || i32.rsp_rdata !== 32'hFFFFFF9C) begin
      fails++; $display("FAIL wait_rsp: valid %b rdata %h want 1 ffffff9c", i32.rsp_valid, i32.rsp_rdata);
    end
  endtask

  task automatic test_timeout;
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    req32(1'b0, SZ_W, 1'b0, 32'h40, '0);
    for (int c = 0; c < 20 && !seen; c++) begin
      if (i32.bus_req) n++;
      if (i32.rsp_valid) begin
        seen = 1'b1;
        checks++;
        if (i32.rsp_err !== 1'b1) begin fails++; $display("FAIL tmo_err: got %b want 1", i32.rsp_err); end
      end else @(negedge clk);
    end
    checks++;
    if (!seen || n != 4) begin fails++; $display("FAIL tmo_len: rsp seen %0d req cycles %0d want 1 4", seen, n); end
    @(negedge clk);
  endtask

  task automatic test_beat1_err;
    req32(1'b0, SZ_H, 1'b1, 32'h103, '0);
    ack32(32'hFFFFFFFF, 1'b1);
    checks++;
    if ({i32.rsp_valid, i32.rsp_err, i32.bus_req} !== 3'b110 || i32.rsp_rdata !== '0) begin
      fails++; $display("FAIL b1err_rsp: valid/err/req %b rdata %h want 110 00000000", {i32.rsp_valid, i32.rsp_err, i32.bus_req}, i32.rsp_rdata);
    end
    @(negedge clk);
    checks++;
    if ({i32.bus_req, i32.rsp_valid} !== 2'b00) begin
      fails++; $display("FAIL b1err_nobeat2: req/rsp %b want 00", {i32.bus_req, i32.rsp_valid});
    end
  endtask

  task automatic test_illegal;
    req32(1'b0, SZ_D, 1'b0, 32'h10, '0);
    checks++;
    if ({i32.rsp_valid, i32.rsp_err, i32.bus_req} !== 3'b110) begin
      fails++; $display("FAIL illegal: valid/err/req %b want 110", {i32.rsp_valid, i32.rsp_err, i32.bus_req});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    req32(1'b1, SZ_B, 1'b0, 32'h301, 32'h000000A5);
    checks++;
    if (i32.bus_wstrb !== 4'b0010 || i32.bus_wdata[15:8] !== 8'hA5 || i32.bus_addr !== 32'h300) begin
      fails++; $display("FAIL b2b_st: strb %b wdata %h addr %h want 0010 xxxxa5xx 00000300", i32.bus_wstrb, i32.bus_wdata, i32.bus_addr);
    end
    ack32('0, 1'b0);
    i32.req_valid = 1'b1; i32.req_we = 1'b0; i32.req_size = SZ_W; i32.req_addr = 32'h400;
    @(negedge clk);
    checks++;
    if ({i32.req_ready, i32.rsp_valid, i32.bus_req} !== 3'b100) begin
      fails++; $display("FAIL b2b_idle: ready/rsp/req %b want 100", {i32.req_ready, i32.rsp_valid, i32.bus_req});
    end
    @(negedge clk);
    i32.req_valid = 1'b0;
    checks++;
    if (i32.bus_req !== 1'b1 || i32.bus_addr !== 32'h400) begin
      fails++; $display("FAIL b2b_accept: req %b addr %h want 1 00000400", i32.bus_req, i32.bus_addr);
    end
    ack32(32'h12345678, 1'b0);
    checks++;
    if (i32.rsp_valid !== 1'b1 || i32.rsp_rdata !== 32'h12345678) begin
      fails++; $display("FAIL b2b_rsp: valid %b rdata %h want 1 12345678", i32.rsp_valid, i32.rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_dword_wrap;
    @(negedge clk);
    i64.req_valid = 1'b1; i64.req_we = 1'b0; i64.req_size = SZ_D; i64.req_signed = 1'b0;
    i64.req_addr = 64'hFFFFFFFFFFFFFFFC;
    @(negedge clk);
    i64.req_valid = 1'b0;
    checks++;
    if (i64.bus_addr !== 64'hFFFFFFFFFFFFFFF8 || i64.bus_wstrb !== 8'h00) begin
      fails++; $display("FAIL dw_b1: addr %h strb %b want fffffffffffffff8 00000000", i64.bus_addr, i64.bus_wstrb);
    end
    i64.bus_ack = 1'b1; i64.bus_rdata = 64'h44332211_00000000;
    @(negedge clk);
    i64.bus_rdata = 64'h00000000_88776655;
    checks++;
    if (i64.bus_req !== 1'b1 || i64.bus_addr !== 64'h0) begin
      fails++; $display("FAIL dw_wrap: req %b addr %h want 1 0000000000000000", i64.bus_req, i64.bus_addr);
    end
    @(negedge clk);
    i64.bus_ack = 1'b0; i64.bus_rdata = '0;
    checks++;
    if ({i64.rsp_valid, i64.rsp_err} !== 2'b10 || i64.rsp_rdata !== 64'h8877665544332211) begin
      fails++; $display("FAIL dw_rdata: valid/err %b rdata %h want 10 8877665544332211", {i64.rsp_valid, i64.rsp_err}, i64.rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    req32(1'b0, SZ_H, 1'b0, 32'h103, '0);
    ack32(32'h11111111, 1'b0);
    checks++;
    if (i32.bus_req !== 1'b1 || i32.bus_addr !== 32'h104) begin
      fails++; $display("FAIL rstmid_b2: req %b addr %h want 1 00000104", i32.bus_req, i32.bus_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({i32.bus_req, i32.req_ready} !== 2'b01) begin
      fails++; $display("FAIL rstmid_async: req/ready %b want 01", {i32.bus_req, i32.req_ready});
    end
    #1 rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({i32.rsp_valid, i32.req_ready, i32.bus_req} !== 3'b010) begin
        fails++; $display("FAIL rstmid_quiet%0d: rsp/ready/req %b want 010", c, {i32.rsp_valid, i32.req_ready, i32.bus_req});
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_split_load(1'b1, 32'hFFFFFF80);
    test_split_load(1'b0, 32'h0000FF80);
    test_split_store();
    test_wait_states();
    test_timeout();
    test_beat1_err();
    test_illegal();
    test_back_to_back();
    test_dword_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
